// File: rtl/shift_iter.sv
// Serial shift unit: SL/SRL/SRA/LUI/HAM, one bit position per clock.
// Define SHIFT_ITER_HAM_EN to build the Hamming-weight (HAM) operation.
module shift_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic [2:0]  func,
    input  logic        start,
    output logic [31:0] C,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_SL,
        OP_SRL,
        OP_SRA,
        OP_LUI,
        OP_HAM
    } op_t;

    state_t      state, state_nx;
    op_t         op, dec_op;
    logic [31:0] acc;
    logic [31:0] acc_ld;
    logic [5:0]  cnt;
    logic [5:0]  n_ld;
    logic [5:0]  sh_n;
    logic [31:0] res;
`ifdef SHIFT_ITER_HAM_EN
    logic [5:0]  hw;
`endif

    // Out-of-range amounts saturate to 32 steps, giving 0 or sign fill.
    assign sh_n = (|Y[31:5]) ? 6'd32 : {1'b0, Y[4:0]};

    always_comb begin
        dec_op = OP_SL;
        acc_ld = X;
        n_ld   = sh_n;
        unique case (1'b1)
            func[2]:          dec_op = OP_SL;
            func == 3'b000:   dec_op = OP_SRL;
            func == 3'b001:   dec_op = OP_SRA;
            func == 3'b010: begin
                dec_op = OP_LUI;
                acc_ld = {Y[15:0], 16'h0000};
                n_ld   = 6'd0;
            end
            func == 3'b011: begin
                dec_op = OP_HAM;
`ifdef SHIFT_ITER_HAM_EN
                n_ld   = 6'd32;
`else
                acc_ld = 32'h0;
                n_ld   = 6'd0;
`endif
            end
            default:          dec_op = OP_SL;
        endcase
    end

`ifdef SHIFT_ITER_HAM_EN
    assign res = (op == OP_HAM) ? {26'h0, hw} : acc;
`else
    assign res = acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                if (cnt == 6'd0) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 32'h0;
            cnt <= 6'd0;
            op  <= OP_SL;
            C   <= 32'h0;
`ifdef SHIFT_ITER_HAM_EN
            hw  <= 6'd0;
`endif
        end else if (state == S_IDLE && start) begin
            acc <= acc_ld;
            cnt <= n_ld;
            op  <= dec_op;
`ifdef SHIFT_ITER_HAM_EN
            hw  <= 6'd0;
`endif
        end else if (state == S_RUN) begin
            if (cnt != 6'd0) begin
                cnt <= cnt - 6'd1;
                case (op)
                    OP_SL:   acc <= {acc[30:0], 1'b0};
                    OP_SRL:  acc <= {1'b0, acc[31:1]};
                    OP_SRA:  acc <= {acc[31], acc[31:1]};
`ifdef SHIFT_ITER_HAM_EN
                    OP_HAM: begin
                        acc <= {1'b0, acc[31:1]};
                        hw  <= hw + {5'd0, acc[0]};
                    end
`endif
                    default: acc <= acc;
                endcase
            end else begin
                C <= res;
            end
        end
    end

endmodule

// File: tb/tb_shift_iter.sv
// Directed-vector bench for shift_iter.
// Expected HAM results follow SHIFT_ITER_HAM_EN.
module tb_shift_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic [2:0]  func = '0;
    logic        start = 1'b0;
    logic [31:0] C;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    shift_iter dut (
        .clk   (clk),
        .rst   (rst),
        .X     (X),
        .Y     (Y),
        .func  (func),
        .start (start),
        .C     (C),
        .busy  (busy),
        .done  (done)
    );

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Latency counts the accept edge as 1; done is seen N+2 edges in.
    task automatic run_op(input string tag, input logic [31:0] x,
                          input logic [31:0] y, input logic [2:0] f,
                          input logic [31:0] exp_c, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        X = x; Y = y; func = f; start = 1'b1;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            #1 start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_c"}, C, exp_c);
        @(posedge clk);
        #1 chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        int lat;
        bit seen;
        logic [5:0] dpat;

        #12 rst = 1'b0;
        #1;
        chk("rst_c", C, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        run_op("pre", 32'hFF, 32'd3, 3'b100, 32'h7F8, 5);

        // Asynchronous reset between edges during a run.
        @(negedge clk);
        X = 32'h1; Y = 32'd8; func = 3'b100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_c", C, 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk) rst = 1'b0;

        run_op("sl3", 32'h1, 32'd3, 3'b100, 32'h8, 5);
        run_op("sra4", 32'h80000010, 32'd4, 3'b001, 32'hF8000001, 6);
        run_op("srl4", 32'h80000010, 32'd4, 3'b000, 32'h08000001, 6);
        run_op("sra_sat", 32'h80000010, 32'h40, 3'b001, 32'hFFFFFFFF, 34);
        run_op("srl_sat", 32'h80000010, 32'h40, 3'b000, 32'h0, 34);
        run_op("sl_sat", 32'hFFFFFFFF, 32'h80000000, 3'b110, 32'h0, 34);
        run_op("lui", 32'h5555, 32'h0000ABCD, 3'b010, 32'hABCD0000, 2);
        run_op("sl0", 32'h1234, 32'd0, 3'b100, 32'h1234, 2);
        run_op("sl31", 32'h1, 32'd31, 3'b111, 32'h80000000, 33);
        run_op("sra_pos", 32'h40000000, 32'd30, 3'b001, 32'h1, 32);
`ifdef SHIFT_ITER_HAM_EN
        run_op("ham", 32'hF0F0000F, 32'd0, 3'b011, 32'd12, 34);
`else
        run_op("ham", 32'hF0F0000F, 32'd0, 3'b011, 32'd0, 2);
`endif

        // A start pulse while busy must be ignored.
        d0 = done_cnt;
        @(negedge clk);
        X = 32'h80000010; Y = 32'd4; func = 3'b000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 begin X = 32'hFFFF; func = 3'b100; start = 1'b1; end
        @(posedge clk);
        #1 start = 1'b0;
        lat = 4;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            #1;
        end
        chk("ign_done", 32'(seen), 32'd1);
        chk("ign_lat", lat, 6);
        chk("ign_c", C, 32'h08000001);
        repeat (10) @(posedge clk);
        #1;
        chk("ign_ndone", done_cnt - d0, 1);
        chk("ign_busy", 32'(busy), 32'd0);

        // Held start: LUI repeats every 3 cycles.
        @(negedge clk);
        X = 32'h0; Y = 32'h1234; func = 3'b010; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 dpat[i] = done;
            if (i == 2) chk("hold_gap", 32'(busy), 32'd0);
        end
        start = 1'b0;
        chk("hold_pat", 32'(dpat), 32'b010010);
        chk("hold_c", C, 32'h12340000);
        repeat (4) @(posedge clk);

        // Reset in RUN cycle 5 of a 10-bit shift aborts with no done.
        @(negedge clk);
        X = 32'h1; Y = 32'd10; func = 3'b100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        d0 = done_cnt;
        @(negedge clk) rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("abort_ndone", done_cnt - d0, 0);
        chk("abort_c", C, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
